skinny_isbox8_hpc2_1_ctrl: RTL and testbench

- First-order HPC2-masked SKINNY-128 inverse 8-bit S-box with its own sequencing controller, for the decryption / tag-verification datapath.
- Accepts a 2-share byte plus 16 bits of fresh randomness over a valid/ready handshake.
- Holds operands stable internally for the full gadget latency, then presents registered output shares with valid/ready.
- Internally uses the same masked (x NOR y) XOR z core gadget as the forward S-box, with two register stages per gadget.

---
 rtl/skinny_isbox8_hpc2_1_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_skinny_isbox8_hpc2_1_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/skinny_isbox8_hpc2_1_ctrl.sv
// skinny_isbox8_hpc2_1_ctrl
// First-order HPC2-masked SKINNY-128 inverse 8-bit S-box with its own sequencer.
//
// Eight masked (x NOR y) XOR z gadgets are arranged in four dependency levels.
// Each gadget has two register stages:
//   - stage 1 registers the refreshed second operand;
//   - stage 2 registers the per-share partial products.
// Operands sit in hold registers for the whole BUSY phase, so every gadget
// level settles in turn.
//
// Optional build macro: SKINNY_ISBOX_ZEROIZE_EN
//   - When defined, the DONE->IDLE handshake edge clears the hold registers
//     and the bo registers.
//
// Gadget slot order, with its randomness pair r[2g+1:2g]:
//   g0:b2  g1:b3  g2:b7  g3:b5  g4:b1  g5:b0  g6:b6  g7:b4
module skinny_isbox8_hpc2_1_ctrl #(
    parameter int SHARES = 2,
    parameter int LAT    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  si0,
    input  logic [7:0]  si1,
    input  logic [15:0] r,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  bo0,
    output logic [7:0]  bo1
);

    if (SHARES != 2) begin : g_bad_shares
        $error("skinny_isbox8_hpc2_1_ctrl supports SHARES=2 only");
    end
    if (LAT != 8) begin : g_bad_lat
        $error("skinny_isbox8_hpc2_1_ctrl supports LAT=8 only");
    end

    localparam logic [3:0] CNT_LAST = 4'(LAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [3:0]  cnt_r;
    logic        out_valid_r;
    logic [7:0]  bo0_r, bo1_r;
    logic [7:0]  o0_r, o1_r;
    logic [15:0] r_r;
    logic        accept_s, load_s, release_s;

    // Gadget-slot operand vectors (one bit per gadget) and per-share results.
    logic [7:0]  gx0_s, gx1_s, gy0_s, gy1_s, gz0_s, gz1_s;
    logic [7:0]  rh_s, rl_s;
    logic [7:0]  ya0_s, ya1_s, xa0_s, xa1_s;
    logic [7:0]  by0_r, by1_r, bx0_r, bx1_r;
    logic [7:0]  p0_r, p1_r;
    logic [7:0]  gc0_s, gc1_s;
    logic [7:0]  v0_s, v1_s;

    assign in_ready  = (state_r == IDLE);
    assign out_valid = out_valid_r;
    assign bo0       = bo0_r;
    assign bo1       = bo1_r;

    // Gadget interconnect: operand routing, randomness split, NOR share inversion.
    always_comb begin
        gx0_s = {v0_s[7], v0_s[2], v0_s[3], o0_r[5], o0_r[6], o0_r[2], o0_r[7], o0_r[3]};
        gx1_s = {v1_s[7], v1_s[2], v1_s[3], o1_r[5], o1_r[6], o1_r[2], o1_r[7], o1_r[3]};
        gy0_s = {v0_s[6], v0_s[1], v0_s[2], v0_s[3], o0_r[5], o0_r[7], o0_r[6], o0_r[1]};
        gy1_s = {v1_s[6], v1_s[1], v1_s[2], v1_s[3], o1_r[5], o1_r[7], o1_r[6], o1_r[1]};
        gz0_s = {o0_r[6], o0_r[2], o0_r[5], o0_r[3], o0_r[7], o0_r[1], o0_r[4], o0_r[0]};
        gz1_s = {o1_r[6], o1_r[2], o1_r[5], o1_r[3], o1_r[7], o1_r[1], o1_r[4], o1_r[0]};
        rh_s  = {r_r[15], r_r[13], r_r[11], r_r[9], r_r[7], r_r[5], r_r[3], r_r[1]};
        rl_s  = {r_r[14], r_r[12], r_r[10], r_r[8], r_r[6], r_r[4], r_r[2], r_r[0]};
        // NOR(x,y) = AND(~x,~y); a share-wise complement only touches share 0.
        xa0_s = ~gx0_s;
        xa1_s = gx1_s;
        ya0_s = ~gy0_s;
        ya1_s = gy1_s;
        gc0_s = p0_r ^ gz0_s;
        gc1_s = p1_r ^ gz1_s;
        v0_s  = {gc0_s[2], gc0_s[6], gc0_s[3], gc0_s[7], gc0_s[1], gc0_s[0], gc0_s[4], gc0_s[5]};
        v1_s  = {gc1_s[2], gc1_s[6], gc1_s[3], gc1_s[7], gc1_s[1], gc1_s[0], gc1_s[4], gc1_s[5]};
    end

    // Gadget stage 1: register own-share y and the cross-share y refreshed with the upper random bit.
    always_ff @(posedge clk) begin
        by0_r <= ya0_s;
        by1_r <= ya1_s;
        bx0_r <= ya1_s ^ rh_s;
        bx1_r <= ya0_s ^ rh_s;
    end

    // Gadget stage 2: per-share HPC2 partial products, remasked with the lower random bit.
    always_ff @(posedge clk) begin
        p0_r <= (xa0_s & by0_r) ^ (xa0_s & bx0_r) ^ (~xa0_s & rh_s) ^ rl_s;
        p1_r <= (xa1_s & by1_r) ^ (xa1_s & bx1_r) ^ (~xa1_s & rh_s) ^ rl_s;
    end

    // Sequencer next-state decode and handshake strobes.
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        load_s    = 1'b0;
        release_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    accept_s = 1'b1;
                    state_s  = BUSY;
                end else begin
                    state_s  = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == CNT_LAST) begin
                    load_s  = 1'b1;
                    state_s = DONE;
                end else begin
                    state_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    release_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    state_s   = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register and latency counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            if (state_r == BUSY && !load_s) begin
                cnt_r <= cnt_r + 4'd1;
            end else begin
                cnt_r <= 4'd0;
            end
        end
    end

    // Operand hold registers: captured once per operation, stable through BUSY.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o0_r <= 8'h00;
            o1_r <= 8'h00;
            r_r  <= 16'h0000;
        end else if (accept_s) begin
            o0_r <= si0;
            o1_r <= si1;
            r_r  <= r;
`ifdef SKINNY_ISBOX_ZEROIZE_EN
        end else if (release_s) begin
            o0_r <= 8'h00;
            o1_r <= 8'h00;
            r_r  <= 16'h0000;
`endif
        end else begin
            o0_r <= o0_r;
            o1_r <= o1_r;
            r_r  <= r_r;
        end
    end

    // Output share registers and valid flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bo0_r       <= 8'h00;
            bo1_r       <= 8'h00;
            out_valid_r <= 1'b0;
        end else if (load_s) begin
            bo0_r       <= v0_s;
            bo1_r       <= v1_s;
            out_valid_r <= 1'b1;
        end else if (release_s) begin
`ifdef SKINNY_ISBOX_ZEROIZE_EN
            bo0_r       <= 8'h00;
            bo1_r       <= 8'h00;
`else
            bo0_r       <= bo0_r;
            bo1_r       <= bo1_r;
`endif
            out_valid_r <= 1'b0;
        end else begin
            bo0_r       <= bo0_r;
            bo1_r       <= bo1_r;
            out_valid_r <= out_valid_r;
        end
    end

endmodule

// File: tb/tb_skinny_isbox8_hpc2_1_ctrl.sv
// Directed testbench for skinny_isbox8_hpc2_1_ctrl.
module tb_skinny_isbox8_hpc2_1_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  si0, si1;
    logic [15:0] r;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  bo0, bo1;

    int errors = 0;
    int checks = 0;

    skinny_isbox8_hpc2_1_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .si0       (si0),
        .si1       (si1),
        .r         (r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bo0       (bo0),
        .bo1       (bo1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Forward SKINNY-8 S-box, obtained by undoing the inverse levels in reverse order.
    function automatic logic [7:0] fwd(input logic [7:0] b);
        logic [7:0] o;
        o[6] = b[4] ^ ~(b[7] | b[6]);
        o[2] = b[6] ^ ~(b[2] | b[1]);
        o[5] = b[0] ^ ~(b[3] | b[2]);
        o[3] = b[1] ^ ~(o[5] | b[3]);
        o[7] = b[5] ^ ~(o[6] | o[5]);
        o[1] = b[7] ^ ~(o[2] | o[7]);
        o[4] = b[3] ^ ~(o[7] | o[6]);
        o[0] = b[2] ^ ~(o[3] | o[1]);
        return o;
    endfunction

    // Issue one operand (out_ready assumed high) and return the result plus its latency.
    task automatic do_op(input logic [7:0] s0, input logic [7:0] s1, input logic [15:0] rr,
                         output logic [7:0] q0, output logic [7:0] q1, output int lat);
        int k;
        k = 0;
        while (in_ready !== 1'b1 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        si0 = s0; si1 = s1; r = rr; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        for (int j = 1; j <= 30; j++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                lat = j;
                break;
            end
        end
        q0 = bo0;
        q1 = bo1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (bo0 !== 8'h00) begin errors++; $display("FAIL reset_bo0 got=%h exp=00", bo0); end
        checks++; if (bo1 !== 8'h00) begin errors++; $display("FAIL reset_bo1 got=%h exp=00", bo1); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_first();
        logic [7:0] q0, q1;
        int lat;
        do_op(8'h65, 8'h00, 16'h0000, q0, q1, lat);
        checks++; if (lat !== 9) begin errors++; $display("FAIL first_latency got=%0d exp=9", lat); end
        checks++; if ((q0 ^ q1) !== 8'h00) begin errors++; $display("FAIL first_value got=%h exp=00", q0 ^ q1); end
    endtask

    task automatic test_masks();
        logic [7:0] q0, q1, first_bo0;
        int lat;
        bit varied;
        do_op(8'h4C ^ 8'hA3, 8'hA3, 16'h5A3C, q0, q1, lat);
        checks++; if ((q0 ^ q1) !== 8'h01) begin errors++; $display("FAIL mask_fixed got=%h exp=01", q0 ^ q1); end
        varied = 1'b0;
        first_bo0 = 8'h00;
        for (int i = 0; i < 32; i++) begin
            do_op(8'h4C ^ 8'hA3, 8'hA3, 16'($urandom), q0, q1, lat);
            checks++; if ((q0 ^ q1) !== 8'h01) begin errors++; $display("FAIL mask_rand%0d got=%h exp=01", i, q0 ^ q1); end
            if (i == 0) first_bo0 = q0;
            else if (q0 !== first_bo0) varied = 1'b1;
        end
        checks++; if (varied !== 1'b1) begin errors++; $display("FAIL mask_bo0_varies got=%b exp=1", varied); end
        do_op(8'hFF ^ 8'h3E, 8'h3E, 16'hFFFF, q0, q1, lat);
        checks++; if ((q0 ^ q1) !== 8'hFF) begin errors++; $display("FAIL mask_ff got=%h exp=ff", q0 ^ q1); end
    endtask

    task automatic test_retain();
        logic [7:0] q0, q1;
        int lat;
        do_op(8'h4C ^ 8'h5D, 8'h5D, 16'h1234, q0, q1, lat);
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL retain_valid got=%b exp=0", out_valid); end
`ifdef SKINNY_ISBOX_ZEROIZE_EN
        checks++; if (bo0 !== 8'h00 || bo1 !== 8'h00) begin errors++; $display("FAIL zeroize_bo got=%h/%h exp=00/00", bo0, bo1); end
        checks++; if (dut.o0_r !== 8'h00 || dut.o1_r !== 8'h00 || dut.r_r !== 16'h0000) begin
            errors++; $display("FAIL zeroize_hold got=%h/%h/%h exp=0", dut.o0_r, dut.o1_r, dut.r_r); end
`else
        checks++; if ((bo0 ^ bo1) !== 8'h01) begin errors++; $display("FAIL retain_bo got=%h exp=01", bo0 ^ bo1); end
`endif
    endtask

    task automatic test_backpressure();
        logic [7:0] h0, h1;
        int k;
        out_ready = 1'b0;
        si0 = 8'hFF ^ 8'h77; si1 = 8'h77; r = 16'hC3A5; in_valid = 1'b1;
        @(posedge clk); #1;
        si0 = 8'h65; si1 = 8'h00; r = 16'h0000;
        k = 0;
        while (out_valid !== 1'b1 && k < 30) begin
            in_valid = (k % 2 == 0);
            @(posedge clk); #1;
            k++;
        end
        checks++; if (k !== 9) begin errors++; $display("FAIL bp_latency got=%0d exp=9", k); end
        checks++; if ((bo0 ^ bo1) !== 8'hFF) begin errors++; $display("FAIL bp_value got=%h exp=ff", bo0 ^ bo1); end
        h0 = bo0; h1 = bo1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || bo0 !== h0 || bo1 !== h1) begin
                errors++; $display("FAIL bp_hold%0d got=v%b rdy%b %h/%h exp=v1 rdy0 %h/%h", i, out_valid, in_ready, bo0, bo1, h0, h1);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release got=v%b rdy%b exp=v0 rdy1", out_valid, in_ready); end
        repeat (12) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_no_ghost got=v%b rdy%b exp=v0 rdy1", out_valid, in_ready); end
    endtask

    task automatic test_midop_reset();
        logic [7:0] q0, q1;
        int lat;
        si0 = 8'h65 ^ 8'h9E; si1 = 8'h9E; r = 16'hBEEF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || bo0 !== 8'h00 || bo1 !== 8'h00) begin
            errors++; $display("FAIL midrst_state got=v%b rdy%b %h/%h exp=v0 rdy1 00/00", out_valid, in_ready, bo0, bo1);
        end
        repeat (12) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_output got=%b exp=0", out_valid); end
        do_op(8'h4C ^ 8'h11, 8'h11, 16'h0F0F, q0, q1, lat);
        checks++; if (lat !== 9 || (q0 ^ q1) !== 8'h01) begin
            errors++; $display("FAIL midrst_after got=lat%0d %h exp=lat9 01", lat, q0 ^ q1); end
    endtask

    task automatic test_sweep();
        logic [7:0] q0, q1, m, y;
        int lat;
        for (int x = 0; x < 256; x++) begin
            y = fwd(8'(x));
            m = 8'($urandom);
            do_op(y ^ m, m, 16'($urandom), q0, q1, lat);
            checks++; if ((q0 ^ q1) !== 8'(x) || lat !== 9) begin
                errors++; $display("FAIL sweep_%02h got=%h lat%0d exp=%h lat9", y, q0 ^ q1, lat, 8'(x));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        si0 = 8'h00; si1 = 8'h00; r = 16'h0000;
        test_reset();
        test_first();
        test_masks();
        test_retain();
        test_backpressure();
        test_midop_reset();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
